// File: rtl/bus_arbiter_pkg.sv
// Shared types for the CPU/PRC bus arbiter: FSM states, bus-owner select, bus request bundle.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    CPU_OWN   = 2'd0,
    HALT_WAIT = 2'd1,
    PRC_OWN   = 2'd2,
    RELEASE   = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_PRC  = 2'd2
  } owner_t;

  typedef struct packed {
    logic [23:0] address;
    logic [7:0]  data;
    logic        read;
    logic        write;
  } bus_req_t;

  localparam int unsigned DEF_HANDOVER_CYCLES = 1;
  localparam logic [15:0] DEF_MAX_HOLD        = 16'd4096;

  // Handover and turnaround states park the bus so neither master's strobes leak.
  function automatic owner_t owner_of(arb_state_t s);
    case (s)
      CPU_OWN: return OWN_CPU;
      PRC_OWN: return OWN_PRC;
      default: return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Shares the system bus between CPU (default) and PRC; halts the CPU at a cycle boundary, then grants.
// Grant after 1+HANDOVER_CYCLES edges, release after 2; PRC ownership bounded by MAX_HOLD.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned HANDOVER_CYCLES = DEF_HANDOVER_CYCLES,
  parameter logic [15:0] MAX_HOLD        = DEF_MAX_HOLD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] cpu_address,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic        cpu_sync,
  output logic        cpu_halt,
  input  logic [23:0] prc_address,
  input  logic [7:0]  prc_data_out,
  input  logic        prc_read,
  input  logic        prc_write,
  input  logic        prc_request,
  output logic        prc_ack,
  output logic [23:0] mem_address,
  output logic [7:0]  mem_data_out,
  output logic        mem_read,
  output logic        mem_write,
  output logic        hold_overrun,
  input  logic        stat_clear,
  output logic [15:0] stolen_cycles
);

  localparam logic [2:0]  HANDOVER_LAST = 3'(HANDOVER_CYCLES);
  localparam logic [15:0] HOLD_LAST     = MAX_HOLD - 16'd1;

  arb_state_t  state, state_nxt;
  logic        cpu_halt_nxt, prc_ack_nxt, overrun_nxt;
  logic        lockout, lockout_nxt;
  logic [2:0]  wait_cnt, wait_cnt_nxt;
  logic [15:0] hold_cnt, hold_cnt_nxt;
  bus_req_t    cpu_bus, prc_bus, mem_bus;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= CPU_OWN;
      cpu_halt     <= 1'b0;
      prc_ack      <= 1'b0;
      hold_overrun <= 1'b0;
      lockout      <= 1'b0;
      wait_cnt     <= '0;
      hold_cnt     <= '0;
    end else begin
      state        <= state_nxt;
      cpu_halt     <= cpu_halt_nxt;
      prc_ack      <= prc_ack_nxt;
      hold_overrun <= overrun_nxt;
      lockout      <= lockout_nxt;
      wait_cnt     <= wait_cnt_nxt;
      hold_cnt     <= hold_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cpu_halt_nxt = cpu_halt;
    prc_ack_nxt  = prc_ack;
    overrun_nxt  = 1'b0;
    wait_cnt_nxt = wait_cnt;
    hold_cnt_nxt = hold_cnt;
    lockout_nxt  = prc_request ? lockout : 1'b0;
    case (state)
      CPU_OWN: begin
        if (prc_request && cpu_sync && !lockout) begin
          state_nxt    = HALT_WAIT;
          cpu_halt_nxt = 1'b1;
          wait_cnt_nxt = '0;
        end
      end
      HALT_WAIT: begin
        // A withdrawn request wins over a grant that would land this same edge.
        if (!prc_request) begin
          state_nxt = RELEASE;
        end else if (wait_cnt == HANDOVER_LAST) begin
          state_nxt    = PRC_OWN;
          prc_ack_nxt  = 1'b1;
          hold_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_cnt + 3'd1;
        end
      end
      PRC_OWN: begin
        hold_cnt_nxt = hold_cnt + 16'd1;
        if (!prc_request) begin
          state_nxt   = RELEASE;
          prc_ack_nxt = 1'b0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt   = RELEASE;
          prc_ack_nxt = 1'b0;
          overrun_nxt = 1'b1;
          lockout_nxt = 1'b1;
        end
      end
      RELEASE: begin
        state_nxt    = CPU_OWN;
        cpu_halt_nxt = 1'b0;
      end
      default: state_nxt = CPU_OWN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || stat_clear) begin
      stolen_cycles <= '0;
    end else if (state == PRC_OWN && stolen_cycles != 16'hFFFF) begin
      stolen_cycles <= stolen_cycles + 16'd1;
    end
  end

  assign cpu_bus = {cpu_address, cpu_data_out, cpu_read, cpu_write};
  assign prc_bus = {prc_address, prc_data_out, prc_read, prc_write};

  always_comb begin
    mem_bus = '0;
    case (owner_of(state))
      OWN_CPU: mem_bus = cpu_bus;
      OWN_PRC: mem_bus = prc_bus;
      default: mem_bus = '0;
    endcase
  end

  assign mem_address  = mem_bus.address;
  assign mem_data_out = mem_bus.data;
  assign mem_read     = mem_bus.read;
  assign mem_write    = mem_bus.write;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: bus transactions go through a scoreboard queue, control outputs checked inline.
module tb_bus_arbiter;

  typedef struct packed {
    logic [23:0] a;
    logic [7:0]  d;
    logic        r;
    logic        w;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] cpu_address;
  logic [7:0]  cpu_data_out;
  logic        cpu_read, cpu_write, cpu_sync;
  logic        cpu_halt;
  logic [23:0] prc_address;
  logic [7:0]  prc_data_out;
  logic        prc_read, prc_write, prc_request;
  logic        prc_ack;
  logic [23:0] mem_address;
  logic [7:0]  mem_data_out;
  logic        mem_read, mem_write;
  logic        hold_overrun;
  logic        stat_clear;
  logic [15:0] stolen_cycles;

  int   checks = 0;
  int   errors = 0;
  txn_t exp_q[$];

  bus_arbiter #(.HANDOVER_CYCLES(1), .MAX_HOLD(16'd8)) dut (
    .clk(clk), .reset(reset),
    .cpu_address(cpu_address), .cpu_data_out(cpu_data_out),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_sync(cpu_sync),
    .cpu_halt(cpu_halt),
    .prc_address(prc_address), .prc_data_out(prc_data_out),
    .prc_read(prc_read), .prc_write(prc_write), .prc_request(prc_request),
    .prc_ack(prc_ack),
    .mem_address(mem_address), .mem_data_out(mem_data_out),
    .mem_read(mem_read), .mem_write(mem_write),
    .hold_overrun(hold_overrun),
    .stat_clear(stat_clear), .stolen_cycles(stolen_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // Every strobed bus cycle on mem_* must match the next expected transaction.
  always @(negedge clk) begin
    if (mem_read || mem_write) begin
      txn_t act, e;
      act = {mem_address, mem_data_out, mem_read, mem_write};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL mem_unexpected: got a=%h d=%h r=%b w=%b, required no strobe", act.a, act.d, act.r, act.w);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL mem_txn: got a=%h d=%h r=%b w=%b, required a=%h d=%h r=%b w=%b",
                   act.a, act.d, act.r, act.w, e.a, e.d, e.r, e.w);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    cpu_address = '0; cpu_data_out = 8'h3C; cpu_read = 1'b0; cpu_write = 1'b0; cpu_sync = 1'b0;
    prc_address = '0; prc_data_out = '0; prc_read = 1'b0; prc_write = 1'b0; prc_request = 1'b0;
    stat_clear = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("reset_halt", 32'(cpu_halt), 0);
    chk("reset_ack", 32'(prc_ack), 0);
    chk("reset_overrun", 32'(hold_overrun), 0);
    chk("reset_stolen", 32'(stolen_cycles), 0);

    // CPU owns the bus by default.
    cpu_read = 1'b1; cpu_address = 24'h002080;
    exp_q.push_back({24'h002080, 8'h3C, 1'b1, 1'b0});
    step();
    cpu_read = 1'b0;
    chk("cpu_own_halt", 32'(cpu_halt), 0);
    chk("cpu_own_ack", 32'(prc_ack), 0);

    // Request without sync: no halt.
    prc_request = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("nosync_halt", 32'(cpu_halt), 0);
    end
    cpu_sync = 1'b1;
    step();
    cpu_sync = 1'b0;
    cpu_write = 1'b1; cpu_address = 24'h00DEAD; cpu_data_out = 8'h5A;
    chk("halt_rise", 32'(cpu_halt), 1);
    chk("halt_wait_ack", 32'(prc_ack), 0);
    step();
    chk("gap_ack", 32'(prc_ack), 0);
    step();
    chk("grant_ack", 32'(prc_ack), 1);
    chk("grant_halt", 32'(cpu_halt), 1);

    // PRC owns the bus; concurrent CPU write must be masked.
    prc_write = 1'b1; prc_address = 24'h001000; prc_data_out = 8'hA5;
    exp_q.push_back({24'h001000, 8'hA5, 1'b0, 1'b1});
    step();
    prc_write = 1'b0; prc_read = 1'b1; prc_address = 24'h001234; prc_data_out = 8'h11;
    exp_q.push_back({24'h001234, 8'h11, 1'b1, 1'b0});
    step();
    prc_read = 1'b0;
    prc_request = 1'b0;
    step();
    cpu_write = 1'b0;
    chk("release_ack", 32'(prc_ack), 0);
    chk("release_halt", 32'(cpu_halt), 1);
    step();
    chk("release_halt_low", 32'(cpu_halt), 0);
    chk("stolen_after_3", 32'(stolen_cycles), 3);
    stat_clear = 1'b1;
    step();
    stat_clear = 1'b0;
    chk("stat_clear_idle", 32'(stolen_cycles), 0);

    // Hold limit: 8 PRC cycles then forced release and lockout.
    prc_request = 1'b1; cpu_sync = 1'b1;
    step(); step(); step();
    chk("ovr_grant", 32'(prc_ack), 1);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("ovr_hold_ack", 32'(prc_ack), 1);
      chk("ovr_hold_pulse", 32'(hold_overrun), 0);
    end
    step();
    chk("ovr_ack_drop", 32'(prc_ack), 0);
    chk("ovr_pulse", 32'(hold_overrun), 1);
    chk("ovr_stolen", 32'(stolen_cycles), 8);
    step();
    chk("ovr_pulse_end", 32'(hold_overrun), 0);
    chk("ovr_halt_low", 32'(cpu_halt), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("lockout_halt", 32'(cpu_halt), 0);
    end
    prc_request = 1'b0;
    step();
    prc_request = 1'b1;
    step();
    chk("regrant_halt", 32'(cpu_halt), 1);
    step(); step();
    chk("regrant_ack", 32'(prc_ack), 1);
    prc_request = 1'b0; cpu_sync = 1'b0;
    step(); step();
    chk("regrant_release", 32'(cpu_halt), 0);
    chk("stolen_9", 32'(stolen_cycles), 9);

    // Request withdrawn in HALT_WAIT on the edge the grant would land.
    prc_request = 1'b1; cpu_sync = 1'b1;
    step();
    cpu_sync = 1'b0;
    chk("hw_halt", 32'(cpu_halt), 1);
    step();
    prc_request = 1'b0;
    step();
    chk("hw_no_ack", 32'(prc_ack), 0);
    chk("hw_release_halt", 32'(cpu_halt), 1);
    step();
    chk("hw_halt_low", 32'(cpu_halt), 0);
    chk("hw_stolen", 32'(stolen_cycles), 9);
    cpu_read = 1'b1; cpu_address = 24'h00ABCD; cpu_data_out = 8'h42;
    exp_q.push_back({24'h00ABCD, 8'h42, 1'b1, 1'b0});
    step();
    cpu_read = 1'b0;

    // stat_clear coincident with a PRC_OWN increment, then reset mid-ownership.
    prc_request = 1'b1; cpu_sync = 1'b1;
    step(); step(); step();
    cpu_sync = 1'b0;
    chk("sc_grant", 32'(prc_ack), 1);
    step();
    chk("sc_stolen_10", 32'(stolen_cycles), 10);
    stat_clear = 1'b1;
    step();
    stat_clear = 1'b0;
    chk("sc_clear_wins", 32'(stolen_cycles), 0);
    step();
    chk("sc_count_resume", 32'(stolen_cycles), 1);
    reset = 1'b1;
    step();
    chk("rst_mid_ack", 32'(prc_ack), 0);
    chk("rst_mid_halt", 32'(cpu_halt), 0);
    chk("rst_mid_stolen", 32'(stolen_cycles), 0);
    reset = 1'b0; prc_request = 1'b0;
    step();
    cpu_write = 1'b1; cpu_address = 24'h0055AA; cpu_data_out = 8'h77;
    exp_q.push_back({24'h0055AA, 8'h77, 1'b0, 1'b1});
    step();
    cpu_write = 1'b0;
    step(); step();
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
